// File: rtl/rr_mux_n.sv
// N-channel registered multiplexer with per-channel valid/ready handshakes.
// Fixed-select or round-robin arbitration; each output word is tagged with its source channel.
module rr_mux_n #(
  parameter int N     = 8,
  parameter int WIDTH = 8,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int              NP    = 1 << SELW;
  localparam logic [SELW:0]   N_EXT = (SELW+1)'(N);
  localparam logic [SELW-1:0] LAST  = SELW'(N - 1);

  logic [SELW-1:0]  ptr_reg;
  logic             load_en;
  logic [NP-1:0]    valid_pad;
  logic [WIDTH-1:0] words [NP];
  logic [2*N-1:0]   valid_dbl;
  logic [N-1:0]     valid_rot;
  logic             rr_found;
  logic [SELW-1:0]  rr_off;
  logic [SELW:0]    rr_sum;
  logic [SELW-1:0]  rr_idx;
  logic             fix_ok;
  logic [SELW-1:0]  grant_idx;
  logic             grant_valid;

  assign load_en = !out_valid || out_ready;

  // Pad to a power of two so an out-of-range sel simply sees an idle channel.
  assign valid_pad = NP'(in_valid);

  generate
    for (genvar gi = 0; gi < NP; gi++) begin : g_words
      if (gi < N) begin : g_real
        assign words[gi] = in_data[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        assign words[gi] = '0;
      end
    end
  endgenerate

  // Rotate the valid vector so bit 0 is the channel at ptr; the lowest set bit wins.
  assign valid_dbl = {in_valid, in_valid};
  assign valid_rot = valid_dbl[ptr_reg +: N];

  always_comb begin
    rr_found = 1'b0;
    rr_off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (valid_rot[i]) begin
        rr_found = 1'b1;
        rr_off   = SELW'(i);
      end
    end
  end

  assign rr_sum = {1'b0, ptr_reg} + {1'b0, rr_off};
  assign rr_idx = (rr_sum >= N_EXT) ? SELW'(rr_sum - N_EXT) : rr_sum[SELW-1:0];

  assign fix_ok      = valid_pad[sel];
  assign grant_idx   = mode ? rr_idx : sel;
  assign grant_valid = rst_n && load_en && (mode ? rr_found : fix_ok);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ready
      assign in_ready[gi] = grant_valid && (grant_idx == SELW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr_reg   <= '0;
    end else begin
      if (grant_valid) begin
        out_data  <= words[grant_idx];
        out_chan  <= grant_idx;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (grant_valid && mode) begin
        ptr_reg <= (grant_idx == LAST) ? '0 : grant_idx + SELW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_n.sv
// Randomized and directed bench for rr_mux_n (N=6 exercises non-power-of-two wrap and sel >= N).
// A behavioural model predicts grants, in_ready and the output register each cycle.
module tb_rr_mux_n;

  localparam int N    = 6;
  localparam int W    = 8;
  localparam int SELW = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic             mode;
  logic [SELW-1:0]  sel;
  logic [W-1:0]     out_data;
  logic [SELW-1:0]  out_chan;
  logic             out_valid;
  logic             out_ready;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference state
  bit         m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  int         m_chan = 0;
  int         m_ptr  = 0;

  always #5 clk = ~clk;

  rr_mux_n #(.N(N), .WIDTH(W), .SELW(SELW)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Grant the spec rules give for the current inputs; -1 means no grant.
  function automatic int predict_grant();
    int g = -1;
    if (!rst_n) return -1;
    if (m_valid && !out_ready) return -1;
    if (!mode) begin
      if (int'(sel) < N && in_valid[sel]) g = int'(sel);
    end else begin
      for (int k = 0; k < N; k++) begin
        int c = (m_ptr + k) % N;
        if (in_valid[c]) begin
          g = c;
          break;
        end
      end
    end
    return g;
  endfunction

  // One clock: check in_ready mid-cycle, advance the model, check outputs after the edge.
  task automatic step(input string tag);
    int g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    g = predict_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0; m_data = '0; m_chan = 0; m_ptr = 0;
    end else if (g >= 0) begin
      m_data  = in_data[g*W +: W];
      m_chan  = g;
      m_valid = 1'b1;
      if (mode) m_ptr = (g + 1) % N;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".out_data"}, 32'(out_data), 32'(m_data));
    check({tag, ".out_chan"}, 32'(out_chan), 32'(m_chan));
    $display("[TB] %s grant=%0d valid=%0b chan=%0d data=%02h ptr=%0d",
             tag, g, out_valid, out_chan, out_data, m_ptr);
  endtask

  task automatic set_in(input logic rn, input logic md, input logic [SELW-1:0] s,
                        input logic [N-1:0] v, input logic ordy);
    rst_n = rn; mode = md; sel = s; in_valid = v; out_ready = ordy;
  endtask

  task automatic pattern_data();
    for (int k = 0; k < N; k++) in_data[k*W +: W] = W'(8'hA0 + k);
  endtask

  task automatic random_data();
    for (int k = 0; k < N; k++) in_data[k*W +: W] = W'($urandom);
  endtask

  initial begin
    pattern_data();
    set_in(1'b0, 1'b1, '0, '1, 1'b1);
    step("reset0");
    step("reset1");

    // Round-robin, everyone valid: chan 0..5 twice, no bubbles
    set_in(1'b1, 1'b1, '0, '1, 1'b1);
    for (int i = 0; i < 2*N; i++) step("rr_all");

    // Fixed sweep
    for (int s = 0; s < N; s++) begin
      set_in(1'b1, 1'b0, SELW'(s), '1, 1'b1);
      step("fixed_sweep");
    end

    // Sparse round-robin with wrap
    set_in(1'b1, 1'b1, '0, 6'b100100, 1'b1);
    for (int i = 0; i < 5; i++) step("rr_sparse");

    // Backpressure then release with simultaneous pop and load
    set_in(1'b1, 1'b0, 3'd1, '1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      random_data();
      step("bp_hold");
    end
    out_ready = 1'b1;
    step("bp_release");

    // Out-of-range select: drain and stay empty
    set_in(1'b1, 1'b0, 3'd6, '1, 1'b1);
    step("sel6_a");
    step("sel6_b");
    sel = 3'd7;
    step("sel7");

    // Reset in the middle of backpressure discards the held word
    set_in(1'b1, 1'b1, '0, '1, 1'b1);
    step("pre_bp");
    out_ready = 1'b0;
    step("bp2_a");
    step("bp2_b");
    rst_n = 1'b0;
    step("bp2_rst");
    set_in(1'b1, 1'b1, '0, 6'b001000, 1'b1);
    step("after_rst");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      random_data();
      rst_n     = ($urandom_range(0, 99) != 0);
      mode      = 1'($urandom);
      sel       = SELW'($urandom);
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
